// File: rtl/calc_sequencer.sv
// UART calculator sequencer: parses "<A><op><B>=" (or CR), requests one ALU
// operation, then streams the signed decimal result followed by CR LF.
module calc_sequencer #(
  parameter int W            = 16,
  parameter int MAX_DIGITS   = 5,
  parameter int CLKS_TIMEOUT = 400000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [2*W-1:0]   alu_result,
  input  logic             alu_neg,
  input  logic             alu_err,
  output logic             busy,
  output logic             rx_dropped
);

  localparam int RW = 2 * W;

  // Number of decimal digits needed for the largest RW-bit magnitude.
  function automatic int calc_ndig(input int rw);
    logic [63:0] p;
    int          n;
    p = 64'd10;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (p <= ((64'd1 << rw) - 64'd1)) begin
        p = p * 64'd10;
        n++;
      end
    end
    return n;
  endfunction

  localparam int NDIG = calc_ndig(RW);
  localparam int KW   = $clog2(NDIG);
  localparam int CW   = $clog2(MAX_DIGITS + 1);
  localparam int TW   = $clog2(CLKS_TIMEOUT + 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_OPA      = 4'd1;
  localparam logic [3:0] S_OPB      = 4'd2;
  localparam logic [3:0] S_ALU_REQ  = 4'd3;
  localparam logic [3:0] S_ALU_WAIT = 4'd4;
  localparam logic [3:0] S_CONV     = 4'd5;
  localparam logic [3:0] S_SEND_CR  = 4'd6;
  localparam logic [3:0] S_SEND_LF  = 4'd7;
  localparam logic [3:0] S_ERR      = 4'd8;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_DIV   = 8'h2F;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_E     = 8'h45;

  // 10^k as an RW-bit constant; the top power always fits RW bits.
  function automatic logic [RW-1:0] pow10(input logic [KW-1:0] k);
    logic [RW-1:0] p;
    p = RW'(1);
    for (int i = 0; i < NDIG; i++) begin
      if (i < int'(k)) p = p * RW'(10);
    end
    return p;
  endfunction

  logic [3:0]    state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] to_cnt;
  logic          sign_pend;
  logic          started;
  logic [RW-1:0] rem;
  logic [3:0]    dig;
  logic [KW-1:0] kidx;

  logic          is_digit;
  logic [3:0]    dval;
  logic          is_op;
  logic [1:0]    op_code;
  logic [W+3:0]  acc_a;
  logic [W+3:0]  acc_b;
  logic          a_ok;
  logic          b_ok;
  logic [RW-1:0] pw;
  logic          conv_idle;
  logic          conv_sub;
  logic          conv_emit;
  logic          conv_skip;
  logic          conv_sent;
  logic          conv_adv;

  assign busy       = !(state == S_IDLE || state == S_OPA || state == S_OPB);
  assign rx_dropped = rx_valid && busy;
  assign alu_start  = (state == S_ALU_REQ);

  // Byte decode, operand accumulation and digit-conversion step decisions.
  always_comb begin
    is_digit  = (rx_data >= CH_0) && (rx_data <= CH_9);
    dval      = rx_data[3:0];
    is_op     = 1'b1;
    op_code   = 2'b00;
    case (rx_data)
      CH_PLUS:  op_code = 2'b00;
      CH_MINUS: op_code = 2'b01;
      CH_MUL:   op_code = 2'b10;
      CH_DIV:   op_code = 2'b11;
      default:  is_op   = 1'b0;
    endcase
    acc_a     = {4'b0, alu_a} * (W+4)'(10) + (W+4)'(dval);
    acc_b     = {4'b0, alu_b} * (W+4)'(10) + (W+4)'(dval);
    a_ok      = (acc_a[W+3:W] == 4'b0) && (cnt != CW'(MAX_DIGITS));
    b_ok      = (acc_b[W+3:W] == 4'b0) && (cnt != CW'(MAX_DIGITS));
    pw        = pow10(kidx);
    conv_idle = (state == S_CONV) && !tx_valid && !sign_pend;
    conv_sub  = conv_idle && (rem >= pw);
    conv_emit = conv_idle && (rem < pw) && ((dig != 4'd0) || started || (kidx == '0));
    conv_skip = conv_idle && (rem < pw) && !((dig != 4'd0) || started || (kidx == '0));
    conv_sent = (state == S_CONV) && tx_valid && tx_ready && !sign_pend;
    conv_adv  = conv_skip || conv_sent;
  end

  // Result datapath: latch the ALU magnitude, then peel digits by repeated subtraction.
  always_ff @(posedge clk) begin
    if (state == S_ALU_WAIT && alu_done && !alu_err) begin
      rem  <= alu_result;
      dig  <= 4'd0;
      kidx <= KW'(NDIG - 1);
    end else if (conv_sub) begin
      rem <= rem - pw;
      dig <= dig + 4'd1;
    end else if (conv_adv) begin
      dig <= 4'd0;
      if (kidx != '0) kidx <= kidx - 1'b1;
    end
  end

  // Sequencer FSM: parsing, ALU handshake and transmit byte handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 2'b00;
      cnt       <= '0;
      to_cnt    <= '0;
      sign_pend <= 1'b0;
      started   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          to_cnt <= '0;
          if (rx_valid) begin
            if (is_digit) begin
              alu_a <= W'(dval);
              cnt   <= CW'(1);
              state <= S_OPA;
            end else if (rx_data != CH_SP) begin
              state <= S_ERR;
            end
          end
        end
        S_OPA: begin
          if (rx_valid) begin
            to_cnt <= '0;
            if (is_digit) begin
              if (a_ok) begin
                alu_a <= acc_a[W-1:0];
                cnt   <= cnt + 1'b1;
              end else begin
                state <= S_ERR;
              end
            end else if (is_op) begin
              alu_op <= op_code;
              alu_b  <= '0;
              cnt    <= '0;
              state  <= S_OPB;
            end else if (rx_data != CH_SP) begin
              state <= S_ERR;
            end
          end else if (to_cnt == TW'(CLKS_TIMEOUT - 1)) begin
            to_cnt <= '0;
            state  <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_OPB: begin
          if (rx_valid) begin
            to_cnt <= '0;
            if (is_digit) begin
              if (b_ok) begin
                alu_b <= acc_b[W-1:0];
                cnt   <= cnt + 1'b1;
              end else begin
                state <= S_ERR;
              end
            end else if ((rx_data == CH_EQ || rx_data == CH_CR) && cnt != '0) begin
              state <= S_ALU_REQ;
            end else begin
              state <= S_ERR;
            end
          end else if (to_cnt == TW'(CLKS_TIMEOUT - 1)) begin
            to_cnt <= '0;
            state  <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_ALU_REQ: state <= S_ALU_WAIT;
        S_ALU_WAIT: begin
          if (alu_done) begin
            if (alu_err) begin
              state <= S_ERR;
            end else begin
              sign_pend <= alu_neg;
              started   <= 1'b0;
              state     <= S_CONV;
            end
          end
        end
        S_CONV: begin
          if (tx_valid && tx_ready) begin
            tx_valid  <= 1'b0;
            sign_pend <= 1'b0;
          end else if (!tx_valid && sign_pend) begin
            tx_data  <= CH_MINUS;
            tx_valid <= 1'b1;
          end else if (conv_emit) begin
            tx_data  <= CH_0 | {4'h0, dig};
            tx_valid <= 1'b1;
            started  <= 1'b1;
          end
          if (conv_adv && kidx == '0) state <= S_SEND_CR;
        end
        S_ERR: begin
          if (!tx_valid) begin
            tx_data  <= CH_E;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_SEND_CR;
          end
        end
        S_SEND_CR: begin
          if (!tx_valid) begin
            tx_data  <= CH_CR;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_SEND_LF;
          end
        end
        S_SEND_LF: begin
          if (!tx_valid) begin
            tx_data  <= CH_LF;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
